// File: rtl/vga_capture_monitor.sv
// Receive-side VGA monitor: verifies sync timing, locks to the frame, rebuilds active pixel
// coordinates/colour on pixel-enable cycles and produces a per-frame rgb checksum.
module vga_capture_monitor #(
  parameter int H_ACTIVE = 640,
  parameter int H_BACK   = 48,
  parameter int H_SYNC   = 96,
  parameter int H_TOTAL  = 800,
  parameter int V_ACTIVE = 480,
  parameter int V_BACK   = 33,
  parameter int V_SYNC   = 2,
  parameter int V_TOTAL  = 525,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        hSync,
  input  logic        vSync,
  input  logic [7:0]  rgb,
  output logic        locked,
  output logic        pixelValid,
  output logic [9:0]  xPix,
  output logic [9:0]  yPix,
  output logic [7:0]  rgbPix,
  output logic        frameDone,
  output logic [15:0] frameSum,
  output logic [7:0]  errCount,
  output logic [1:0]  dbg_state
);
  typedef enum logic [1:0] {HUNT = 2'd0, CHECK = 2'd1, LOCKED = 2'd2} state_e;

  localparam logic [9:0] CNT_MAX  = 10'h3FF;
  localparam logic [7:0] HSW_MAX  = 8'hFF;
  localparam logic [7:0] ERR_MAX  = 8'hFF;
  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [7:0] H_SYNC_W = 8'(H_SYNC);
  localparam logic [9:0] X_LO     = 10'(H_SYNC + H_BACK);
  localparam logic [9:0] X_HI     = 10'(H_SYNC + H_BACK + H_ACTIVE);
  localparam logic [9:0] Y_LO     = 10'(V_SYNC + V_BACK);
  localparam logic [9:0] Y_HI     = 10'(V_SYNC + V_BACK + V_ACTIVE);

  state_e      state_q, state_d;
  logic        sh_q, sh_d, sv_q, sv_d;
  logic [9:0]  hcnt_q, hcnt_d, vcnt_q, vcnt_d;
  logic [7:0]  hsw_q, hsw_d;
  logic        armed_q, armed_d;
  logic        locked_q, locked_d;
  logic        pv_q, pv_d;
  logic [9:0]  x_q, x_d, y_q, y_d;
  logic [7:0]  rgbp_q, rgbp_d;
  logic        fd_q, fd_d;
  logic [15:0] fsum_q, fsum_d, acc_q, acc_d;
  logic [7:0]  err_q, err_d;

  logic h_asrt, v_asrt, h_edge, v_edge;
  logic line_fail, frame_fail, sat_fail, viol, active;

  assign h_asrt = (hSync == SYNC_POL);
  assign v_asrt = (vSync == SYNC_POL);
  assign h_edge = enable && h_asrt && (sh_q != SYNC_POL);
  assign v_edge = enable && v_asrt && (sv_q != SYNC_POL);

  always_comb begin
    state_d    = state_q;
    sh_d       = sh_q;
    sv_d       = sv_q;
    hcnt_d     = hcnt_q;
    vcnt_d     = vcnt_q;
    hsw_d      = hsw_q;
    armed_d    = armed_q;
    locked_d   = locked_q;
    pv_d       = 1'b0;
    x_d        = x_q;
    y_d        = y_q;
    rgbp_d     = rgbp_q;
    fd_d       = 1'b0;
    fsum_d     = fsum_q;
    acc_d      = acc_q;
    err_d      = err_q;
    line_fail  = 1'b0;
    frame_fail = 1'b0;
    sat_fail   = 1'b0;
    viol       = 1'b0;
    active     = 1'b0;
    if (enable) begin
      sh_d   = hSync;
      sv_d   = vSync;
      hcnt_d = h_edge ? 10'd0 : ((hcnt_q == CNT_MAX) ? CNT_MAX : hcnt_q + 10'd1);
      hsw_d  = h_edge ? 8'd1 : ((h_asrt && hsw_q != HSW_MAX) ? hsw_q + 8'd1 : hsw_q);
      if (v_edge) vcnt_d = 10'd0;
      else if (h_edge) vcnt_d = (vcnt_q == CNT_MAX) ? CNT_MAX : vcnt_q + 10'd1;
      // A frame edge must land on a line edge; a mid-line vSync fails the frame check.
      line_fail  = h_edge && armed_q && (hcnt_q != H_LAST || hsw_q != H_SYNC_W);
      frame_fail = v_edge && (!h_edge || vcnt_q != V_LAST);
      sat_fail   = (hcnt_d == CNT_MAX && hcnt_q != CNT_MAX) ||
                   (vcnt_d == CNT_MAX && vcnt_q != CNT_MAX);
      viol       = (state_q != HUNT) && (line_fail || frame_fail || sat_fail);
      active     = (hcnt_d >= X_LO) && (hcnt_d < X_HI) && (vcnt_d >= Y_LO) && (vcnt_d < Y_HI);
      case (state_q)
        HUNT:    if (v_edge) state_d = CHECK;
        CHECK:   if (viol) state_d = HUNT; else if (v_edge) state_d = LOCKED;
        LOCKED:  if (viol) state_d = HUNT;
        default: state_d = HUNT;
      endcase
      if (viol && err_q != ERR_MAX) err_d = err_q + 8'd1;
      if (state_q == LOCKED && active) begin
        pv_d   = 1'b1;
        x_d    = hcnt_d - X_LO;
        y_d    = vcnt_d - Y_LO;
        rgbp_d = rgb;
      end
      if (state_q == LOCKED && v_edge && !viol) begin
        fd_d   = 1'b1;
        fsum_d = acc_q;
      end
      if (state_d == HUNT || fd_d) acc_d = 16'd0;
      else if (pv_d) acc_d = acc_q + {8'd0, rgb};
      // The first line edge after leaving HUNT has no trustworthy predecessor to measure.
      armed_d  = (state_d == HUNT) ? 1'b0 : (h_edge ? 1'b1 : armed_q);
      locked_d = (state_d == LOCKED);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= HUNT;
      sh_q     <= ~SYNC_POL;
      sv_q     <= ~SYNC_POL;
      hcnt_q   <= 10'd0;
      vcnt_q   <= 10'd0;
      hsw_q    <= 8'd0;
      armed_q  <= 1'b0;
      locked_q <= 1'b0;
      pv_q     <= 1'b0;
      x_q      <= 10'd0;
      y_q      <= 10'd0;
      rgbp_q   <= 8'd0;
      fd_q     <= 1'b0;
      fsum_q   <= 16'd0;
      acc_q    <= 16'd0;
      err_q    <= 8'd0;
    end else begin
      state_q  <= state_d;
      sh_q     <= sh_d;
      sv_q     <= sv_d;
      hcnt_q   <= hcnt_d;
      vcnt_q   <= vcnt_d;
      hsw_q    <= hsw_d;
      armed_q  <= armed_d;
      locked_q <= locked_d;
      pv_q     <= pv_d;
      x_q      <= x_d;
      y_q      <= y_d;
      rgbp_q   <= rgbp_d;
      fd_q     <= fd_d;
      fsum_q   <= fsum_d;
      acc_q    <= acc_d;
      err_q    <= err_d;
    end
  end

  assign locked     = locked_q;
  assign pixelValid = pv_q;
  assign xPix       = x_q;
  assign yPix       = y_q;
  assign rgbPix     = rgbp_q;
  assign frameDone  = fd_q;
  assign frameSum   = fsum_q;
  assign errCount   = err_q;
  assign dbg_state  = state_q;
endmodule

// File: tb/tb_vga_capture_monitor.sv
// Bench for vga_capture_monitor on a scaled-down raster (32x16 total, 16x8 active) so that
// many frames fit in a short run; a sample-indexed reference model predicts every output.
module tb_vga_capture_monitor;
  localparam int H_ACT = 16;
  localparam int H_BK  = 4;
  localparam int H_SY  = 6;
  localparam int H_TOT = 32;
  localparam int V_ACT = 8;
  localparam int V_BK  = 3;
  localparam int V_SY  = 2;
  localparam int V_TOT = 16;

  logic        clk, reset, enable, hsync, vsync;
  logic [7:0]  rgb;
  logic        locked, pixelValid, frameDone;
  logic [9:0]  xPix, yPix;
  logic [7:0]  rgbPix, errCount;
  logic [15:0] frameSum;
  logic [1:0]  dbg_state;

  vga_capture_monitor #(
    .H_ACTIVE(H_ACT), .H_BACK(H_BK), .H_SYNC(H_SY), .H_TOTAL(H_TOT),
    .V_ACTIVE(V_ACT), .V_BACK(V_BK), .V_SYNC(V_SY), .V_TOTAL(V_TOT), .SYNC_POL(1'b0)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .hSync(hsync), .vSync(vsync), .rgb(rgb),
    .locked(locked), .pixelValid(pixelValid), .xPix(xPix), .yPix(yPix), .rgbPix(rgbPix),
    .frameDone(frameDone), .frameSum(frameSum), .errCount(errCount), .dbg_state(dbg_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #3_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

  int n_checks = 0;
  int n_errors = 0;
  int gap_mode = 0;
  int rgb_mode = 0;
  int pv_cnt   = 0;
  int xor_sum  = 0;

  logic [27:0] exp_q[$];

  // reference model state, indexed by enabled-sample number since reset
  int          m_n, m_last_h, m_lines, m_hs_run, m_stage, m_err, m_acc, m_fsum;
  bit          m_prev_ha, m_prev_va, m_armed;
  bit          e_pv, e_fd, e_locked;
  int          e_err, e_fsum;
  logic [27:0] e_last_pix;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_n = 0; m_last_h = -1; m_lines = 0; m_hs_run = 0; m_stage = 0;
    m_err = 0; m_acc = 0; m_fsum = 0; m_prev_ha = 0; m_prev_va = 0; m_armed = 0;
    e_pv = 0; e_fd = 0; e_locked = 0; e_err = 0; e_fsum = 0; e_last_pix = '0;
    exp_q.delete();
  endtask

  task automatic model_step(input logic h, input logic v, input logic [7:0] r);
    bit ha, va, hedge, vedge, line_ok, frame_ok, sat, viol, act;
    int age_prev, hc, lines_new, x, y;
    ha = (h == 1'b0);
    va = (v == 1'b0);
    hedge = ha && !m_prev_ha;
    vedge = va && !m_prev_va;
    age_prev  = m_n - 1 - m_last_h;
    hc        = hedge ? 0 : ((age_prev + 1 > 1023) ? 1023 : age_prev + 1);
    lines_new = vedge ? 0 : (hedge ? ((m_lines + 1 > 1023) ? 1023 : m_lines + 1) : m_lines);
    line_ok   = (age_prev + 1 == H_TOT) && (m_hs_run == H_SY);
    frame_ok  = hedge && (m_lines + 1 == V_TOT);
    sat       = (!hedge && age_prev + 1 == 1023) || (hedge && !vedge && m_lines + 1 == 1023);
    viol      = (m_stage != 0) && ((hedge && m_armed && !line_ok) || (vedge && !frame_ok) || sat);
    x = hc - (H_SY + H_BK);
    y = lines_new - (V_SY + V_BK);
    act  = (m_stage == 2) && x >= 0 && x < H_ACT && y >= 0 && y < V_ACT;
    e_pv = act;
    if (act) begin
      e_last_pix = {10'(x), 10'(y), r};
      exp_q.push_back(e_last_pix);
    end
    e_fd = (m_stage == 2) && vedge && !viol;
    if (e_fd) begin
      m_fsum = m_acc;
      m_acc  = 0;
    end
    if (viol) begin
      m_stage = 0;
      if (m_err < 255) m_err++;
    end else if (vedge && m_stage < 2) begin
      m_stage++;
    end
    if (m_stage == 0) m_acc = 0;
    else if (act) m_acc = (m_acc + int'(r)) % 65536;
    m_armed  = (m_stage != 0) && (hedge || m_armed);
    m_hs_run = hedge ? 1 : (ha ? ((m_hs_run < 255) ? m_hs_run + 1 : 255) : m_hs_run);
    if (hedge) m_last_h = m_n;
    m_lines   = lines_new;
    m_prev_ha = ha;
    m_prev_va = va;
    m_n++;
    e_locked = (m_stage == 2);
    e_err    = m_err;
    e_fsum   = m_fsum;
  endtask

  // scoreboard for the cycle right after an enabled sample
  task automatic observe();
    logic [27:0] exp_pix;
    check("pixel_valid", pixelValid, e_pv);
    if (e_pv) begin
      check("pix_queue_nonempty", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        exp_pix = exp_q.pop_front();
        if (pixelValid) check("pixel_data", {xPix, yPix, rgbPix}, exp_pix);
      end
    end else begin
      check("pixel_hold", {xPix, yPix, rgbPix}, e_last_pix);
    end
    if (pixelValid) pv_cnt++;
    check("frame_done", frameDone, e_fd);
    if (frameDone) begin
      check("pixels_per_frame", pv_cnt, H_ACT * V_ACT);
      pv_cnt = 0;
      if (rgb_mode == 0) check("frame_sum_xor", frameSum, xor_sum);
    end
    check("frame_sum", frameSum, e_fsum);
    check("locked", locked, e_locked);
    if (!locked) pv_cnt = 0;
    check("err_count", errCount, e_err);
  endtask

  // driver: one enabled sample, then optional idle cycles with junk on the inputs
  task automatic send(input logic h, input logic v, input logic [7:0] r);
    int gaps;
    hsync = h; vsync = v; rgb = r; enable = 1'b1;
    model_step(h, v, r);
    @(posedge clk); #1;
    enable = 1'b0;
    observe();
    gaps = (gap_mode != 0) ? 3 + (($urandom_range(0, 3) == 0) ? 1 : 0) : 0;
    for (int g = 0; g < gaps; g++) begin
      hsync = 1'($urandom); vsync = 1'($urandom); rgb = 8'($urandom);
      @(posedge clk); #1;
      check("gap_pixel_valid", pixelValid, 0);
      check("gap_frame_done", frameDone, 0);
      check("gap_locked", locked, e_locked);
      check("gap_pixel_hold", {xPix, yPix, rgbPix}, e_last_pix);
    end
  endtask

  task automatic send_lines(input int l_from, input int l_to, input int bad_line,
                            input int bad_len, input int bad_hs);
    int len, hsw, x, y;
    logic [7:0] r;
    for (int l = l_from; l < l_to; l++) begin
      len = (l == bad_line && bad_len > 0) ? bad_len : H_TOT;
      hsw = (l == bad_line && bad_hs > 0) ? bad_hs : H_SY;
      for (int p = 0; p < len; p++) begin
        x = p - (H_SY + H_BK);
        y = l - (V_SY + V_BK);
        if (x >= 0 && x < H_ACT && y >= 0 && y < V_ACT && rgb_mode == 0) r = 8'(x ^ y);
        else r = 8'($urandom);
        send((p < hsw) ? 1'b0 : 1'b1, (l < V_SY) ? 1'b0 : 1'b1, r);
      end
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; enable = 1'b1; hsync = 1'b0; vsync = 1'b0; rgb = 8'($urandom);
    @(posedge clk); #1;
    reset = 1'b0; enable = 1'b0;
    model_reset();
    pv_cnt = 0;
    check("rst_locked", locked, 0);
    check("rst_pixel_valid", pixelValid, 0);
    check("rst_pixel", {xPix, yPix, rgbPix}, 0);
    check("rst_frame_done", frameDone, 0);
    check("rst_frame_sum", frameSum, 0);
    check("rst_err_count", errCount, 0);
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; hsync = 1'b1; vsync = 1'b1; rgb = 8'd0;
    for (int yy = 0; yy < V_ACT; yy++)
      for (int xx = 0; xx < H_ACT; xx++)
        xor_sum = (xor_sum + ((xx ^ yy) & 255)) % 65536;
    repeat (3) @(posedge clk);
    do_reset();

    // nominal frames: lock on the 2nd vSync edge, then two checksummed frames
    repeat (4) send_lines(0, V_TOT, -1, 0, 0);
    check("t1_locked", locked, 1);

    // one short line while locked, then clean video
    send_lines(0, V_TOT, 5, H_TOT - 1, 0);
    check("t3_err", errCount, 1);
    check("t3_unlocked", locked, 0);
    repeat (3) send_lines(0, V_TOT, -1, 0, 0);
    check("t3_relocked", locked, 1);

    // narrow hSync pulse
    send_lines(0, V_TOT, 3, 0, H_SY - 1);
    check("t4_err_hsw", errCount, 2);
    repeat (3) send_lines(0, V_TOT, -1, 0, 0);
    check("t4_relocked", locked, 1);

    // hSync stuck asserted: counter saturates exactly once
    repeat (2000) send(1'b0, 1'b1, 8'($urandom));
    check("t4_err_stuck", errCount, 3);
    check("t4_stuck_unlocked", locked, 0);
    repeat (3) send_lines(0, V_TOT, -1, 0, 0);
    check("t4_stuck_relocked", locked, 1);

    // sparse enable with random extra idle cycles
    do_reset();
    gap_mode = 1;
    repeat (4) send_lines(0, V_TOT, -1, 0, 0);
    check("t5_locked", locked, 1);
    gap_mode = 0;

    // random colours, reset in the middle of a locked frame
    rgb_mode = 1;
    repeat (3) send_lines(0, V_TOT, -1, 0, 0);
    send_lines(0, 7, -1, 0, 0);
    check("t6_locked_before_reset", locked, 1);
    do_reset();
    send_lines(7, V_TOT, -1, 0, 0);
    repeat (3) send_lines(0, V_TOT, -1, 0, 0);
    check("t6_relocked", locked, 1);
    check("t6_err", errCount, 0);

    check("exp_q_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
